// File: rtl/character_drawer_pkg.sv
// Shared encodings for the character movement FSM and the sprite drawer:
// lane/transition codes, screen geometry and the drawer state enum.
package character_drawer_pkg;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int COLOUR_W = 3;

  // 0..3 are settled lanes; 4..9 are in-flight moves between adjacent lanes
  typedef enum logic [3:0] {
    POS0 = 4'd0, POS1, POS2, POS3,
    T01  = 4'd4, T10, T12, T21, T23, T32
  } lane_state_e;

  typedef enum logic [1:0] {INIT, IDLE, ERASE, DRAW} drawer_state_e;

endpackage

// File: rtl/character_sprite_rom.sv
// 8x8 1-bit player bitmap, row-major, bit 7 is the leftmost pixel.
// Only built when CHAR_DRAW_SPRITE_EN is defined.
`ifdef CHAR_DRAW_SPRITE_EN
module character_sprite_rom (
  input  logic [2:0] row_i,
  input  logic [2:0] col_i,
  output logic       bit_o
);

  logic [7:0] row_bits;

  always_comb begin
    row_bits = 8'h00;
    case (row_i)
      3'd0: row_bits = 8'b0011_1100;
      3'd1: row_bits = 8'b0111_1110;
      3'd2: row_bits = 8'b1101_1011;
      3'd3: row_bits = 8'b1111_1111;
      3'd4: row_bits = 8'b1111_1111;
      3'd5: row_bits = 8'b0110_0110;
      3'd6: row_bits = 8'b0100_0010;
      3'd7: row_bits = 8'b1100_0011;
      default: row_bits = 8'h00;
    endcase
  end

  assign bit_o = row_bits[3'd7 - col_i];

endmodule
`endif

// File: rtl/character_drawer.sv
// Player sprite owner: on a settled-lane change, erases the old lane then draws the
// new one, one registered pixel per cycle. CHAR_DRAW_SPRITE_EN selects the bitmap sprite.
module character_drawer
  import character_drawer_pkg::*;
#(
  parameter int                  SPRITE_W   = 8,
  parameter int                  SPRITE_H   = 8,
  parameter int                  LANE_X0    = 20,
  parameter int                  LANE_PITCH = 40,
  parameter int                  Y_POS      = 100,
  parameter logic [COLOUR_W-1:0] FG_COLOUR  = 3'b111,
  parameter logic [COLOUR_W-1:0] BG_COLOUR  = 3'b000
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [3:0]          CurrState,
  output logic [7:0]          X,
  output logic [6:0]          Y,
  output logic [COLOUR_W-1:0] Colour,
  output logic                Plot,
  output logic                Busy
);

  localparam int PXW = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam int PYW = (SPRITE_H > 1) ? $clog2(SPRITE_H) : 1;

  if ((LANE_X0 + 3*LANE_PITCH + SPRITE_W - 1 > SCREEN_W - 1) ||
      (Y_POS + SPRITE_H - 1 > SCREEN_H - 1)) begin : g_bad_geometry
    $error("character_drawer: sprite placement exceeds the 160x120 framebuffer");
  end

  drawer_state_e       state_q, state_d;
  logic [1:0]          drawn_q, drawn_d, target_q, target_d, pass_lane;
  logic [PXW-1:0]      px_q, px_d;
  logic [PYW-1:0]      py_q, py_d;
  logic [7:0]          x_q, x_d;
  logic [6:0]          y_q, y_d;
  logic [COLOUR_W-1:0] col_q, col_d, draw_col;
  logic                plot_q, plot_d, busy_q, busy_d;

`ifdef CHAR_DRAW_SPRITE_EN
  logic sprite_bit;
  character_sprite_rom u_rom (
    .row_i (3'(py_q)),
    .col_i (3'(px_q)),
    .bit_o (sprite_bit)
  );
  assign draw_col = sprite_bit ? FG_COLOUR : BG_COLOUR;
`else
  assign draw_col = FG_COLOUR;
`endif

  assign pass_lane = (state_q == ERASE) ? drawn_q : target_q;

  always_comb begin
    state_d  = state_q;
    drawn_d  = drawn_q;
    target_d = target_q;
    px_d     = px_q;
    py_d     = py_q;
    x_d      = x_q;
    y_d      = y_q;
    col_d    = col_q;
    plot_d   = 1'b0;
    busy_d   = 1'b0;
    case (state_q)
      INIT: begin
        target_d = 2'd0;
        px_d     = '0;
        py_d     = '0;
        state_d  = DRAW;
      end
      IDLE: begin
        // transition codes are ignored; only a settled, different lane triggers a move
        if (CurrState <= POS3 && CurrState[1:0] != drawn_q) begin
          target_d = CurrState[1:0];
          state_d  = ERASE;
        end
      end
      ERASE, DRAW: begin
        plot_d = 1'b1;
        busy_d = 1'b1;
        x_d    = 8'(LANE_X0) + 8'(pass_lane) * 8'(LANE_PITCH) + 8'(px_q);
        y_d    = 7'(Y_POS) + 7'(py_q);
        col_d  = (state_q == ERASE) ? BG_COLOUR : draw_col;
        if (px_q == PXW'(SPRITE_W - 1)) begin
          px_d = '0;
          if (py_q == PYW'(SPRITE_H - 1)) begin
            py_d = '0;
            if (state_q == ERASE) begin
              state_d = DRAW;
            end else begin
              drawn_d = target_q;
              state_d = IDLE;
            end
          end else begin
            py_d = py_q + 1'b1;
          end
        end else begin
          px_d = px_q + 1'b1;
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q  <= INIT;
      drawn_q  <= 2'd0;
      target_q <= 2'd0;
      px_q     <= '0;
      py_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      col_q    <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      drawn_q  <= drawn_d;
      target_q <= target_d;
      px_q     <= px_d;
      py_q     <= py_d;
      x_q      <= x_d;
      y_q      <= y_d;
      col_q    <= col_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
    end
  end

  assign X      = x_q;
  assign Y      = y_q;
  assign Colour = col_q;
  assign Plot   = plot_q;
  assign Busy   = busy_q;

endmodule
